// File: rtl/coll_pkg.sv
// coll_pkg: control-word layout, FSM encoding and buffer entry type
// shared by the channel collector and its skid buffer.
package coll_pkg;

  localparam int CW_FLAG   = 15;
  localparam int CW_CH_HI  = 14;
  localparam int CW_CH_LO  = 9;
  localparam int CW_LEN_HI = 8;
  localparam int CW_LEN_LO = 0;

  localparam int TMO_DEF = 255;

  localparam logic [0:0] S_POLL = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  typedef struct packed {
    logic        last;
    logic [15:0] word;
  } skid_t;

  function automatic logic is_cw(input logic [15:0] w);
    return w[CW_FLAG];
  endfunction

  function automatic logic [8:0] cw_len(input logic [15:0] w);
    return w[CW_LEN_HI:CW_LEN_LO];
  endfunction

  function automatic logic [5:0] cw_ch(input logic [15:0] w);
    return w[CW_CH_HI:CW_CH_LO];
  endfunction

endpackage

// File: rtl/coll_skid2.sv
// coll_skid2: two-entry valid/ready buffer of {last, word};
// count lets the producer stop requesting before it can overflow.
module coll_skid2
  import coll_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  skid_t      wdata,
  input  logic       rdy,
  output skid_t      rdata,
  output logic       valid,
  output logic [1:0] count
);

  skid_t head;
  skid_t tail;
  logic  pop;

  assign valid = (count != 2'd0);
  assign pop   = valid & rdy;
  assign rdata = head;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= wdata;
          else tail <= wdata;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= wdata;
          end else begin
            head <= tail;
            tail <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/chan_collector.sv
// chan_collector: round-robin block reader over NCH channel
// processors, CW-framed, streamed out through a 2-entry skid buffer.
module chan_collector
  import coll_pkg::*;
#(
  parameter int NCH = 16,
  parameter int TMO = TMO_DEF
)(
  input  logic              clk,
  input  logic              reset,
  output logic [NCH-1:0]    give,
  input  logic [NCH-1:0]    have,
  input  logic [16*NCH-1:0] din,
  output logic [15:0]       dout,
  output logic              dvalid,
  input  logic              dready,
  output logic              dlast,
  output logic              blk_done,
  output logic              err_frame,
  output logic              err_tmo
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW = $clog2(TMO + 1);
  localparam logic [PW-1:0] PMAX = PW'(NCH - 1);

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [8:0]    remain;
  logic [IW-1:0] idle;
  logic [1:0]    cnt;
  logic          room;
  logic          sel_have;
  logic          xfer;
  logic          push;
  logic          push_last;
  logic [15:0]   word;
  skid_t         wdat;
  skid_t         head;
  logic          hvalid;

  // Holding give low in reset keeps a channel from losing a word
  assign room     = (cnt != 2'd2) & ~reset;
  assign sel_have = have[ptr];
  assign word     = din[{ptr, 4'h0} +: 16];
  assign xfer     = room & sel_have;
  assign ptr_nxt  = (ptr == PMAX) ? '0 : ptr + 1'b1;

  always_comb begin
    give = '0;
    if (room) give[ptr] = 1'b1;
  end

  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    if (xfer) begin
      unique case (1'b1)
        (state == S_POLL): begin
          push      = is_cw(word);
          push_last = (cw_len(word) == 9'd0);
        end
        (state == S_BODY): begin
          push      = 1'b1;
          push_last = (remain == 9'd1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_POLL;
      ptr       <= '0;
      remain    <= '0;
      idle      <= '0;
      blk_done  <= 1'b0;
      err_frame <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      blk_done  <= push & push_last;
      err_frame <= xfer & (state == S_POLL) & ~is_cw(word);
      err_tmo   <= 1'b0;
      if (room) begin
        unique case (1'b1)
          (state == S_POLL): begin
            if (!sel_have) begin
              ptr <= ptr_nxt;
            end else if (is_cw(word)) begin
              remain <= cw_len(word);
              idle   <= '0;
              if (cw_len(word) == 9'd0) ptr <= ptr_nxt;
              else state <= S_BODY;
            end
          end
          (state == S_BODY): begin
            if (sel_have) begin
              remain <= remain - 9'd1;
              idle   <= '0;
              if (remain == 9'd1) begin
                ptr   <= ptr_nxt;
                state <= S_POLL;
              end
            end else if (idle == IW'(TMO - 1)) begin
              err_tmo <= 1'b1;
              idle    <= '0;
              ptr     <= ptr_nxt;
              state   <= S_POLL;
            end else begin
              idle <= idle + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wdat = {push_last, word};

  coll_skid2 u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdat),
    .rdy   (dready),
    .rdata (head),
    .valid (hvalid),
    .count (cnt)
  );

  assign dout   = head.word;
  assign dvalid = hvalid;
  assign dlast  = hvalid & head.last;

endmodule
